// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready handshake and sent one bit per shift_en edge, LSB-first or
// MSB-first. The frame drives a serial-in shift register directly:
//   - dout is that register's data input.
//   - tx_sl drives its shift-left control. Data enters at the MSB and moves
//     toward bit 0, which suits an LSB-first frame.
//   - tx_sr drives its shift-right control. Data enters at bit 0 and moves
//     toward the MSB, which suits an MSB-first frame.
// A new word may be accepted on the last-bit edge, so frames stream with no
// idle bit between them.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high reset
//   load_valid  in   load_data / lsb_first valid this cycle
//   load_ready  out  a word can be accepted this cycle (depends on shift_en)
//   load_data   in   [WIDTH-1:0] word to transmit
//   lsb_first   in   bit order captured with the word (1: bit 0 first)
//   shift_en    in   bit-rate enable, one bit consumed per enabled edge
//   dout        out  current serial bit, stable across stalls
//   dout_valid  out  dout is consumed at the next edge
//   tx_sl       out  receiver shift-left control (LSB-first frame)
//   tx_sr       out  receiver shift-right control (MSB-first frame)
//   busy        out  frame in progress
//   done        out  one-cycle pulse after the final bit is consumed
// ----------------------------------------------------------------------------
module piso_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             tx_sl,
    output logic             tx_sr,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;
    logic               done_q;

    logic               shifting;
    logic               last_bit;
    logic               bit_taken;
    logic               accept;

    // Frame status and the handshake. Only registers and shift_en feed the
    // outputs; load_valid and load_data only reach the state registers.
    always_comb begin
        shifting  = (state_q == SHIFT);
        last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
        bit_taken = shifting && shift_en;
        accept    = load_valid && load_ready;
    end

    // Output decode. In IDLE every output is 0 except load_ready.
    always_comb begin
        load_ready = !shifting || (last_bit && shift_en);
        busy       = shifting;
        dout       = 1'b0;
        if (shifting) begin
            dout = dir_q ? shreg_q[0] : shreg_q[WIDTH-1];
        end
        dout_valid = bit_taken;
        tx_sl      = bit_taken && dir_q;
        tx_sr      = bit_taken && !dir_q;
        done       = done_q;
    end

    // Frame state machine and datapath. A load accepted on the last-bit edge
    // takes priority over the final shift, so the next frame starts at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= bit_taken && last_bit;
            if (accept) begin
                state_q <= SHIFT;
                shreg_q <= load_data;
                dir_q   <= lsb_first;
                cnt_q   <= '0;
            end else if (bit_taken) begin
                // Move the next bit to the outgoing end, zero-filling behind it.
                shreg_q <= dir_q ? {1'b0, shreg_q[WIDTH-1:1]}
                                 : {shreg_q[WIDTH-2:0], 1'b0};
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_q <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         lsb_first;
    logic         shift_en;
    logic         dout;
    logic         dout_valid;
    logic         tx_sl;
    logic         tx_sr;
    logic         busy;
    logic         done;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .lsb_first  (lsb_first),
        .shift_en   (shift_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .tx_sl      (tx_sl),
        .tx_sr      (tx_sr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: the frame is a queue of the bits still to be sent.
    logic   m_bits[$];
    logic   m_dir  = 1'b0;
    logic   m_done = 1'b0;

    // Receiver fed by the DUT outputs, plus per-run bookkeeping.
    logic [W-1:0] rx = '0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     done_cnt = 0;
    int     dv_cnt = 0;
    int     sl_cnt = 0;
    int     sr_cnt = 0;
    int     one_cnt = 0;
    int     done_cyc[$];
    logic [W-1:0] rx_at_done[$];
    logic   obs_ready = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_stats();
        rx = '0;
        dv_cnt = 0; sl_cnt = 0; sr_cnt = 0; one_cnt = 0;
        done_cyc.delete();
        rx_at_done.delete();
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // feed the receiver, then advance the model across the rising edge.
    task automatic step(input logic lv, input logic [W-1:0] d, input logic lf, input logic se);
        logic e_busy, e_dout, e_dv, e_rdy;
        @(negedge clk);
        load_valid = lv;
        load_data  = d;
        lsb_first  = lf;
        shift_en   = se;
        #1;
        cyc++;
        e_busy = (m_bits.size() != 0);
        e_dout = e_busy ? m_bits[0] : 1'b0;
        e_dv   = e_busy && se;
        e_rdy  = !e_busy || (m_bits.size() == 1 && se);
        chk1("busy",       busy,       e_busy);
        chk1("dout",       dout,       e_dout);
        chk1("dout_valid", dout_valid, e_dv);
        chk1("tx_sl",      tx_sl,      e_dv && m_dir);
        chk1("tx_sr",      tx_sr,      e_dv && !m_dir);
        chk1("load_ready", load_ready, e_rdy);
        chk1("done",       done,       m_done);
        obs_ready = load_ready;
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc - acc_cyc);
            rx_at_done.push_back(rx);
        end
        if (dout_valid) begin
            dv_cnt++;
            if (dout) one_cnt++;
        end
        if (tx_sl) begin
            sl_cnt++;
            rx = {dout, rx[W-1:1]};
        end
        if (tx_sr) begin
            sr_cnt++;
            rx = {rx[W-2:0], dout};
        end
        @(posedge clk);
        m_done = e_busy && se && (m_bits.size() == 1);
        if (e_busy && se) void'(m_bits.pop_front());
        if (lv && e_rdy) begin
            if (!e_busy || m_bits.size() == 0) acc_cyc = (m_bits.size() == 0 && !e_busy) ? cyc : acc_cyc;
            m_bits.delete();
            for (int i = 0; i < int'(W); i++) m_bits.push_back(lf ? d[i] : d[W-1-i]);
            m_dir = lf;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_ready"}, load_ready, 1'b1);
        chk1({tag, "_busy"},  busy,       1'b0);
        chk1({tag, "_dout"},  dout,       1'b0);
        chk1({tag, "_dv"},    dout_valid, 1'b0);
        chk1({tag, "_sl"},    tx_sl,      1'b0);
        chk1({tag, "_sr"},    tx_sr,      1'b0);
        chk1({tag, "_done"},  done,       1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle with random inputs applied.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        reset      = 1'b1;
        load_valid = 1'($urandom);
        load_data  = W'($urandom);
        lsb_first  = 1'($urandom);
        shift_en   = 1'($urandom);
        #1;
        chk_reset_outputs(tag);
        m_bits.delete();
        m_done = 1'b0;
        m_dir  = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs({tag, "_held"});
        @(negedge clk);
        load_valid = 1'b0;
        reset      = 1'b0;
    endtask

    int d0;

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        lsb_first  = 1'b0;
        shift_en   = 1'b0;
        #3;
        chk_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Reset while idle with random inputs.
        step(1'b0, '0, 1'b0, 1'b1);
        pulse_reset("idle_rst");

        // LSB-first 0xA5, shift_en held high.
        clear_stats();
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        acc_cyc = cyc;
        for (int i = 0; i < 8; i++) step(1'b0, W'($urandom), 1'($urandom), 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk32("lsb_rx",     32'(rx), 32'h0000_00A5);
        chk32("lsb_dv",     dv_cnt, 8);
        chk32("lsb_sl",     sl_cnt, 8);
        chk32("lsb_sr",     sr_cnt, 0);
        chk32("lsb_ndone",  done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk32("lsb_done_cyc", done_cyc[0], 9);

        // MSB-first 0x3C with shift_en alternating 1,0.
        clear_stats();
        step(1'b1, 8'h3C, 1'b0, 1'b1);
        acc_cyc = cyc;
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'($urandom), (i % 2) == 0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk32("msb_rx",     32'(rx), 32'h0000_003C);
        chk32("msb_dv",     dv_cnt, 8);
        chk32("msb_sr",     sr_cnt, 8);
        chk32("msb_sl",     sl_cnt, 0);
        chk32("msb_ndone",  done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk32("msb_done_cyc", done_cyc[0], 16);

        // Back-to-back 0x81 then 0x7E with load_valid held.
        clear_stats();
        step(1'b1, 8'h81, 1'b1, 1'b1);
        acc_cyc = cyc;
        for (int i = 0; i < 8; i++) step(1'b1, 8'h7E, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk32("b2b_dv",     dv_cnt, 16);
        chk32("b2b_ndone",  done_cyc.size(), 2);
        if (done_cyc.size() == 2) begin
            chk32("b2b_done1", done_cyc[0], 9);
            chk32("b2b_done2", done_cyc[1], 17);
            chk32("b2b_rx1",   32'(rx_at_done[0]), 32'h0000_0081);
            chk32("b2b_rx2",   32'(rx_at_done[1]), 32'h0000_007E);
        end

        // Reset after 3 bits of 0x55, then a clean 0xFF frame.
        clear_stats();
        step(1'b1, 8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
        pulse_reset("mid_rst");
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk32("mid_rst_nodone", done_cnt, d0);
        clear_stats();
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        acc_cyc = cyc;
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk32("ff_ones",  one_cnt, 8);
        chk32("ff_rx",    32'(rx), 32'h0000_00FF);
        chk32("ff_ndone", done_cyc.size(), 1);

        // Load presented at bit 4 of an 0xF0 frame is ignored.
        clear_stats();
        step(1'b1, 8'hF0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b1, 1'b1);
        chk1("ign_ready", obs_ready, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk32("ign_rx",    32'(rx), 32'h0000_00F0);
        chk32("ign_ndone", done_cyc.size(), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), W'($urandom), 1'($urandom), ($urandom % 4) != 0);
            if (i == 300) pulse_reset("rnd_rst");
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter that loads a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, LSB-first or MSB-first. It sits on the transmit side of the team's serial byte links. It drives a serial-in shift register directly: dout feeds that register's data input, and tx_sl/tx_sr feed its shift-left/shift-right controls, so the receiver reconstructs the original word after WIDTH shifts. Back-to-back words stream with no idle bit between them.

## Interface
- WIDTH, default 8: word width in bits; legal values are 2 or more.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data and lsb_first are valid this cycle.
- load_ready  output  1  the transmitter can accept a word this cycle.
- load_data  input  WIDTH  word to transmit.
- lsb_first  input  1  bit order, captured with the word: 1 sends bit 0 first, 0 sends bit WIDTH-1 first.
- shift_en  input  1  bit-rate enable; one bit is consumed per edge on which it is high.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout is being consumed at the next edge.
- tx_sl  output  1  receiver shift-left control (LSB-first frame).
- tx_sr  output  1  receiver shift-right control (MSB-first frame).
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the final bit of a frame is consumed.

## Operation
- Internal state:
  - shreg[WIDTH-1:0]: word being shifted.
  - dir: captured lsb_first.
  - cnt[$clog2(WIDTH)-1:0]: bits already sent.
  - state: IDLE or SHIFT.
- IDLE:
  - busy=0, dout=0, dout_valid=0, tx_sl=0, tx_sr=0, load_ready=1.
- Load acceptance: on an edge where load_valid && load_ready:
  - shreg <= load_data, dir <= lsb_first, cnt <= 0, state <= SHIFT.
- SHIFT outputs:
  - busy=1.
  - dout = dir ? shreg[0] : shreg[WIDTH-1]. dout is combinational from registers and is stable whether or not shift_en is high.
  - dout_valid = shift_en.
  - tx_sl = shift_en && dir; tx_sr = shift_en && !dir.
- Shift step: on an edge in SHIFT with shift_en=1:
  - shreg shifts toward the outgoing end and zero-fills: right shift when dir=1, left shift when dir=0.
  - cnt increments.
- Stall: while shift_en=0, shreg, cnt and state hold.
- Last bit: the last bit is being sent when cnt==WIDTH-1.
  - load_ready = IDLE || (SHIFT && last bit && shift_en).
  - On the last-bit edge, state goes to IDLE, or stays in SHIFT with the new word loaded if a load is accepted on that same edge.
- done: registered; high for exactly the one cycle following each last-bit edge, including during a back-to-back frame.
- load_valid while load_ready=0: ignored; no capture, and no effect on the frame in progress.
- load_valid and lsb_first are sampled only on accept; changing lsb_first mid-frame has no effect.

## Timing
- Reset, asynchronous: state=IDLE, shreg=0, cnt=0, dir=0, done=0.
  - All outputs are 0 except load_ready=1, immediately and for as long as reset is high.
- Reset mid-frame: the frame is aborted with no done pulse. The first edge after reset is released may accept a load.
- Latency:
  - Accept edge to first dout_valid opportunity: the next cycle.
  - A frame with shift_en held high occupies exactly WIDTH cycles of dout_valid.
  - done is high in cycle WIDTH+1 after the accept edge.
- Throughput: with load_valid and shift_en held high, frames are contiguous, giving 1 bit per cycle with no gap.
- No combinational path from load_valid or load_data to any output. load_ready, dout_valid, tx_sl and tx_sr depend combinationally on shift_en.

## Test plan
- Reset behaviour: assert reset mid-idle with random inputs -> load_ready=1 and every other output 0 while reset is high.
- LSB-first frame: load 0xA5 with lsb_first=1, shift_en held at 1 -> dout = 1,0,1,0,0,1,0,1 over 8 cycles with tx_sl=1 and tx_sr=0, done pulses in cycle 9. Feeding dout/tx_sl/tx_sr into a serial-in register yields 0xA5.
- MSB-first frame with stalls: load 0x3C with lsb_first=0, shift_en alternating 1,0 -> dout bits 0,0,1,1,1,1,0,0, each held across its stall cycle, with tx_sr=1 only on enabled cycles. Exactly 8 enabled edges, then one done pulse; the receiver yields 0x3C.
- Back-to-back frames: load_valid held with 0x81 then 0x7E (lsb_first=1) -> 16 contiguous dout_valid cycles, the second word accepted on the last-bit edge of the first, and done pulses in cycles 9 and 17.
- Reset mid-frame: assert reset after 3 bits of 0x55 -> outputs go to 0 immediately and no done pulse. A following load of 0xFF then sends eight 1s and one done pulse.
- Load ignored when not ready: present load_valid with 0x00 at bit 4 of an 0xF0 frame -> load_ready=0 and the frame completes as 0xF0 unchanged.
